switch_sync: RTL
================

# switch_sync

Parametrised, debounced, registered input stage for the board switches. It replaces the plain one-register switch buffer. Each switch bit passes through a synchroniser and an optional per-bit debounce filter. The block presents a stable `Sdata` word to the datapath, plus per-bit edge pulses and a sticky change flag that the controller acknowledges.

## Interface
Parameters:
- `WORD_W`, 8: number of switch bits.
- `SYNC_STAGES`, 2: synchroniser flops per bit; legal range ≥ 2.
- `DB_CYCLES`, 4: consecutive cycles a synchronised bit must differ from `Sdata` before `Sdata` updates; legal range ≥ 1. Used only with debounce compiled in.

Ports:
- `clock`, in, 1: single clock; all state updates on the rising edge.
- `n_reset`, in, 1: asynchronous, active-low reset.
- `switches`, in, `WORD_W`: raw asynchronous switch levels.
- `Sdata`, out, `WORD_W`: registered, filtered switch word.
- `Srise`, out, `WORD_W`: one-cycle pulse per bit when that `Sdata` bit goes 0→1.
- `Sfall`, out, `WORD_W`: one-cycle pulse per bit when that `Sdata` bit goes 1→0.
- `Schanged`, out, 1: sticky flag; set when any `Sdata` bit has changed since the last acknowledge.
- `Sack`, in, 1: synchronous acknowledge that clears `Schanged`.

## Operation
- Reset (`n_reset` low, asynchronous):
  - all synchroniser flops, debounce counters, `Sdata`, `Srise`, `Sfall` and `Schanged` go to 0 immediately.
  - Reset mid-filter discards partial counts.
- Synchroniser: `SYNC_STAGES` flops per bit; `sync[i]` is the last stage.
- Debounce (per bit, independent), with `cnt[i]` of width `$clog2(DB_CYCLES)` (minimum 1 bit):
  - `sync[i] == Sdata[i]`: `cnt[i]` ← 0.
  - `sync[i] != Sdata[i]` and `cnt[i] == DB_CYCLES-1`: `Sdata[i]` ← `sync[i]`, `cnt[i]` ← 0.
  - otherwise: `cnt[i]` ← `cnt[i]+1`.
  - A glitch shorter than `DB_CYCLES` synchronised cycles never reaches `Sdata`.
  - The counter never wraps: it restarts on any matching sample.
- Edge pulses: `Srise[i]`/`Sfall[i]` are registered and high for exactly the one cycle after the edge where `Sdata[i]` updates. Otherwise they are 0.
- `Schanged`:
  - any bit update → 1.
  - `Sack` high with no update on the same edge → 0.
  - update and `Sack` on the same edge → update wins, stays 1.
  - `Sack` while `Schanged` is 0 has no effect.
- Out-of-reset behaviour: switches held high through reset are reported as rising edges after the normal latency.

## Timing
- Latency, debounce in: `switches` change settling before edge 1 → `Sdata` updates on edge `SYNC_STAGES+DB_CYCLES`. Default is edge 6.
- Latency, debounce out: `Sdata` updates on edge `SYNC_STAGES+1`.
- `Srise`/`Sfall`/`Schanged` change on the same edge as `Sdata`.
- `Schanged` clears on the edge that samples `Sack`.
- All outputs come directly from flops; no combinational input→output path.

## Configuration
- `SWITCH_DEBOUNCE_EN` defined: debounce counters are built as described; `DB_CYCLES` applies.
- Not defined: no counters. `Sdata` ← `sync` every cycle, `DB_CYCLES` is ignored, and edges/`Schanged` derive from that update.

## Test plan
- Reset: `switches`=8'hFF, `n_reset` low then released → `Sdata`=8'h00 during reset; with defaults, `Sdata`=8'hFF, `Srise`=8'hFF for one cycle and `Schanged`=1 on edge 6 after release.
- Glitch reject: bit 3 high for 3 cycles with `DB_CYCLES`=4 → `Sdata` unchanged, no pulses, `Schanged` stays 0. Without the macro: `Sdata[3]` pulses high for 3 cycles.
- Stable change: `switches` 8'h00→8'h81, held → `Sdata`=8'h81 on edge 6, `Srise`=8'h81 for one cycle, `Schanged`=1.
- Acknowledge race:
  - `Sack` on the same edge as a new update → `Schanged` stays 1.
  - `Sack` on the next cycle → `Schanged`=0.
- Independent bits: bit 0 falls while bit 7 bounces every 2 cycles → only `Sfall[0]` pulses; `Sdata`[7] is held.
- Async reset mid-count: `n_reset` pulsed low between clock edges while `cnt` is 2 → all outputs 0 at once; a fresh full latency applies after release.

Source files
------------

// File: rtl/switch_sync_if.sv
// Switch input bundle: raw switch levels and acknowledge in, filtered word, edge pulses and change flag out.
interface switch_sync_if #(
  parameter int WORD_W = 8
);
  logic [WORD_W-1:0] switches;
  logic [WORD_W-1:0] Sdata;
  logic [WORD_W-1:0] Srise;
  logic [WORD_W-1:0] Sfall;
  logic              Schanged;
  logic              Sack;

  modport master (
    output switches, Sack,
    input  Sdata, Srise, Sfall, Schanged
  );

  modport slave (
    input  switches, Sack,
    output Sdata, Srise, Sfall, Schanged
  );
endinterface

// File: rtl/switch_sync.sv
// Synchronised, optionally debounced (SWITCH_DEBOUNCE_EN) switch word with edge pulses and sticky change flag.
// Latency SYNC_STAGES+DB_CYCLES edges (SYNC_STAGES+1 without debounce); no backpressure, Sack only clears Schanged.
module switch_sync #(
  parameter int WORD_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 4
) (
  input  logic          clock,
  input  logic          n_reset,
  switch_sync_if.slave  sw
);

  if (SYNC_STAGES < 2 || DB_CYCLES < 1) begin : g_param_chk
    $error("switch_sync: SYNC_STAGES must be >= 2 and DB_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0][WORD_W-1:0] sync_q, sync_d;
  logic [WORD_W-1:0] sdata_q, sdata_d;
  logic [WORD_W-1:0] rise_q, rise_d;
  logic [WORD_W-1:0] fall_q, fall_d;
  logic              changed_q, changed_d;
  logic [WORD_W-1:0] sync;

`ifdef SWITCH_DEBOUNCE_EN
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  logic [WORD_W-1:0][CW-1:0] cnt_q, cnt_d;
`endif

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = sw.switches;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end

    sdata_d = sdata_q;
`ifdef SWITCH_DEBOUNCE_EN
    cnt_d = cnt_q;
    // Any matching sample restarts the run, so the counter can never wrap.
    for (int i = 0; i < WORD_W; i++) begin
      if (sync[i] == sdata_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        sdata_d[i] = sync[i];
        cnt_d[i]   = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
`else
    sdata_d = sync;
`endif

    rise_d = sdata_d & ~sdata_q;
    fall_d = ~sdata_d & sdata_q;

    // A fresh update outranks an acknowledge landing on the same edge.
    if (sdata_d != sdata_q) begin
      changed_d = 1'b1;
    end else if (sw.Sack) begin
      changed_d = 1'b0;
    end else begin
      changed_d = changed_q;
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync_q    <= '0;
      sdata_q   <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
`ifdef SWITCH_DEBOUNCE_EN
      cnt_q     <= '0;
`endif
    end else begin
      sync_q    <= sync_d;
      sdata_q   <= sdata_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
`ifdef SWITCH_DEBOUNCE_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign sw.Sdata    = sdata_q;
  assign sw.Srise    = rise_q;
  assign sw.Sfall    = fall_q;
  assign sw.Schanged = changed_q;

endmodule
